// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd6,
    ST_TRAP = 3'd7
  } stage_e;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE,
    C_OPIMM, C_OP, C_MD, C_SYS
  } iclass_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_AND  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SRA  = 5'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [1:0] A_RS1   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_IMM  = 2'd1;
  localparam logic [1:0] B_FOUR = 2'd2;

  typedef struct packed {
    iclass_e    cls;
    logic [4:0] alu;
    logic [2:0] imm;
    logic       is_sign;
    logic       legal;
  } dec_t;

  function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << lo;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Memory handshake bundle between the control FSM (master) and memories (slave).
// MD_START exists only when CTRL_MULDIV_EN is defined.
interface multicycle_ctrl_fsm_if;
  logic       I_MEM_REQ;
  logic       I_MEM_RDY;
  logic       D_MEM_REQ;
  logic       D_MEM_RDY;
  logic       D_MEM_WEN;
  logic [3:0] D_MEM_BE;
  logic [1:0] addr_lo;
  logic       MD_DONE;
`ifdef CTRL_MULDIV_EN
  logic       MD_START;

  modport master (output I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, D_MEM_BE, MD_START,
                  input  I_MEM_RDY, D_MEM_RDY, addr_lo, MD_DONE);
  modport slave  (input  I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, D_MEM_BE, MD_START,
                  output I_MEM_RDY, D_MEM_RDY, addr_lo, MD_DONE);
`else
  modport master (output I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, D_MEM_BE,
                  input  I_MEM_RDY, D_MEM_RDY, addr_lo, MD_DONE);
  modport slave  (input  I_MEM_REQ, D_MEM_REQ, D_MEM_WEN, D_MEM_BE,
                  output I_MEM_RDY, D_MEM_RDY, addr_lo, MD_DONE);
`endif
endinterface

// File: rtl/multicycle_ctrl_fsm_decode.sv
// Combinational RV32I decode: class, ALU op, immediate format, legality.
// RV32M encodings are legal only when CTRL_MULDIV_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] alu_f3;
  logic       unused_bits;

  assign opc = inst_i[6:0];
  assign f3  = inst_i[14:12];
  assign f7  = inst_i[31:25];
  assign unused_bits = ^{inst_i[24:15], inst_i[11:7]};

  // inst[30] selects SRA for both register and immediate shifts
  always_comb begin
    case (f3)
      3'b000:  alu_f3 = ALU_ADD;
      3'b001:  alu_f3 = ALU_SLL;
      3'b010:  alu_f3 = ALU_SLT;
      3'b011:  alu_f3 = ALU_SLTU;
      3'b100:  alu_f3 = ALU_XOR;
      3'b101:  alu_f3 = inst_i[30] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_f3 = ALU_OR;
      default: alu_f3 = ALU_AND;
    endcase
  end

  always_comb begin
    dec_o.cls     = C_OP;
    dec_o.alu     = ALU_ADD;
    dec_o.imm     = IMM_I;
    dec_o.is_sign = 1'b0;
    dec_o.legal   = 1'b0;
    case (opc)
      OP_LUI:   begin dec_o.cls = C_LUI;   dec_o.imm = IMM_U; dec_o.legal = 1'b1; end
      OP_AUIPC: begin dec_o.cls = C_AUIPC; dec_o.imm = IMM_U; dec_o.legal = 1'b1; end
      OP_JAL:   begin dec_o.cls = C_JAL;   dec_o.imm = IMM_J; dec_o.legal = 1'b1; end
      OP_JALR:  begin dec_o.cls = C_JALR;  dec_o.legal = (f3 == 3'b000); end
      OP_BRANCH: begin
        dec_o.cls     = C_BRANCH;
        dec_o.imm     = IMM_B;
        dec_o.is_sign = !f3[1];
        dec_o.legal   = (f3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        dec_o.cls     = C_LOAD;
        dec_o.is_sign = !f3[2];
        dec_o.legal   = (f3[1:0] != 2'b11) && !(f3[2] && f3[1]);
      end
      OP_STORE: begin
        dec_o.cls   = C_STORE;
        dec_o.imm   = IMM_S;
        dec_o.legal = !f3[2] && (f3[1:0] != 2'b11);
      end
      OP_IMM: begin
        dec_o.cls = C_OPIMM;
        dec_o.alu = alu_f3;
        if (f3 == 3'b001)      dec_o.legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) dec_o.legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   dec_o.legal = 1'b1;
      end
      OP_REG: begin
        if (f7 == 7'b0000000) begin
          dec_o.alu   = alu_f3;
          dec_o.legal = 1'b1;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          dec_o.alu   = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          dec_o.legal = 1'b1;
        end
`ifdef CTRL_MULDIV_EN
        else if (f7 == 7'b0000001) begin
          dec_o.cls   = C_MD;
          dec_o.alu   = {2'b10, f3};
          dec_o.legal = 1'b1;
        end
`endif
      end
      OP_SYSTEM: begin dec_o.cls = C_SYS; dec_o.legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control FSM: sequences IF/ID/EX/MEM/WB per instruction class.
// Define CTRL_MULDIV_EN for RV32M decode with an MD_START/MD_DONE multi-cycle EX.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          INST,
  input  logic [1:0]           br_control,
  multicycle_ctrl_fsm_if.master mem,
  output logic                 PC_WE,
  output logic                 IR_WE,
  output logic                 RF_WE,
  output logic                 ALU_REG_WE,
  output logic                 is_sign,
  output logic [1:0]           ASel,
  output logic [1:0]           BSel,
  output logic [4:0]           alu_control,
  output logic [1:0]           wbSel,
  output logic                 pcSel,
  output logic [2:0]           imm_control,
  output logic [2:0]           stage,
  output logic                 ILLEGAL,
  output logic                 MISALIGN,
  output logic                 TIMEOUT,
  output logic                 HALT,
  output logic [INSTRET_W-1:0] INSTRET
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  stage_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 ill_q, ill_d, mis_q, mis_d, to_q, to_d, halt_q, halt_d;
  dec_t                 dec;
  logic                 taken, wait_c, md_start;
  logic                 i_req, d_req, d_wen;
  logic [3:0]           d_be;

  ctrl_decode u_dec (.inst_i(INST), .dec_o(dec));

  always_comb begin
    case (INST[14:12])
      3'b000:         taken = br_control[1];
      3'b001:         taken = !br_control[1];
      3'b100, 3'b110: taken = !br_control[1] && br_control[0];
      3'b101, 3'b111: taken = !br_control[0];
      default:        taken = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IF;
      cnt_q     <= '0;
      instret_q <= '0;
      ill_q     <= 1'b0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
      ill_q     <= ill_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
      halt_q    <= halt_d;
    end
  end

  // Outputs are forced to their idle values while RST is high so a reset
  // landing mid-instruction commits nothing.
  always_comb begin
    state_d     = state_q;
    ill_d       = ill_q;
    mis_d       = mis_q;
    to_d        = to_q;
    halt_d      = halt_q;
    i_req       = 1'b0;
    d_req       = 1'b0;
    d_wen       = 1'b1;
    d_be        = 4'b0000;
    PC_WE       = 1'b0;
    IR_WE       = 1'b0;
    RF_WE       = 1'b0;
    ALU_REG_WE  = 1'b0;
    is_sign     = 1'b0;
    ASel        = A_RS1;
    BSel        = B_RS2;
    alu_control = ALU_ADD;
    wbSel       = WB_ALU;
    pcSel       = 1'b0;
    imm_control = IMM_I;
    wait_c      = 1'b0;
    md_start    = 1'b0;
    if (!RST) begin
      case (state_q)
        ST_IF: begin
          i_req = 1'b1;
          ASel  = A_PC;
          BSel  = B_FOUR;
          if (mem.I_MEM_RDY) begin
            IR_WE = 1'b1;
            PC_WE = 1'b1;
            if (!dec.legal) begin
              state_d = ST_TRAP;
              ill_d   = 1'b1;
            end else begin
              case (dec.cls)
                C_SYS:        begin state_d = ST_HALT; halt_d = 1'b1; end
                C_LUI:        state_d = ST_WB;
                C_AUIPC,
                C_JAL:        state_d = ST_EX;
                default:      state_d = ST_ID;
              endcase
            end
          end else begin
            wait_c = 1'b1;
            if (cnt_q == TO_LAST) begin
              state_d = ST_TRAP;
              to_d    = 1'b1;
            end
          end
        end
        ST_ID: begin
          imm_control = dec.imm;
          is_sign     = dec.is_sign;
          if (dec.cls == C_BRANCH) begin
            ASel       = A_OLDPC;
            BSel       = B_IMM;
            ALU_REG_WE = 1'b1;
          end
          state_d = ST_EX;
        end
        ST_EX: begin
          imm_control = dec.imm;
          is_sign     = dec.is_sign;
          alu_control = dec.alu;
          state_d     = ST_WB;
          case (dec.cls)
            C_BRANCH: begin
              pcSel   = 1'b1;
              PC_WE   = taken;
              state_d = ST_IF;
            end
            C_JAL: begin
              ASel  = A_OLDPC;
              BSel  = B_IMM;
              PC_WE = 1'b1;
            end
            C_JALR: begin
              BSel  = B_IMM;
              PC_WE = 1'b1;
            end
            C_AUIPC: begin
              ASel       = A_OLDPC;
              BSel       = B_IMM;
              ALU_REG_WE = 1'b1;
            end
            C_OP: ALU_REG_WE = 1'b1;
`ifdef CTRL_MULDIV_EN
            // cnt_q only stays zero on the first EX cycle while MD_DONE is low
            C_MD: begin
              md_start = (cnt_q == 8'd0);
              if (mem.MD_DONE) begin
                ALU_REG_WE = 1'b1;
              end else begin
                wait_c  = 1'b1;
                state_d = ST_EX;
                if (cnt_q == TO_LAST) begin
                  state_d = ST_TRAP;
                  to_d    = 1'b1;
                end
              end
            end
`endif
            C_LOAD, C_STORE: begin
              BSel       = B_IMM;
              ALU_REG_WE = 1'b1;
              state_d    = ST_MEM;
            end
            default: begin
              BSel       = B_IMM;
              ALU_REG_WE = 1'b1;
            end
          endcase
        end
        ST_MEM: begin
          imm_control = dec.imm;
          is_sign     = dec.is_sign;
          if (misaligned(INST[13:12], mem.addr_lo)) begin
            state_d = ST_TRAP;
            mis_d   = 1'b1;
          end else begin
            d_req = 1'b1;
            d_wen = (dec.cls != C_STORE);
            d_be  = be_mask(INST[13:12], mem.addr_lo);
            if (mem.D_MEM_RDY) begin
              state_d = (dec.cls == C_STORE) ? ST_IF : ST_WB;
            end else begin
              wait_c = 1'b1;
              if (cnt_q == TO_LAST) begin
                state_d = ST_TRAP;
                to_d    = 1'b1;
              end
            end
          end
        end
        ST_WB: begin
          RF_WE       = 1'b1;
          imm_control = dec.imm;
          is_sign     = dec.is_sign;
          case (dec.cls)
            C_JAL, C_JALR: wbSel = WB_PC;
            C_LUI:         wbSel = WB_IMM;
            C_LOAD:        wbSel = WB_MEM;
            default:       wbSel = WB_ALU;
          endcase
          state_d = ST_IF;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (state_d != state_q) cnt_d = '0;
    else if (wait_c)        cnt_d = cnt_q + 8'd1;
    else                    cnt_d = cnt_q;
    if (state_q != ST_IF && state_d == ST_IF)
      instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    else
      instret_d = instret_q;
  end

  assign mem.I_MEM_REQ = i_req;
  assign mem.D_MEM_REQ = d_req;
  assign mem.D_MEM_WEN = d_wen;
  assign mem.D_MEM_BE  = d_be;
`ifdef CTRL_MULDIV_EN
  assign mem.MD_START  = md_start;
`else
  logic unused_md;
  assign unused_md = mem.MD_DONE ^ md_start;
`endif

  assign stage    = state_q;
  assign ILLEGAL  = ill_q;
  assign MISALIGN = mis_q;
  assign TIMEOUT  = to_q;
  assign HALT     = halt_q;
  assign INSTRET  = instret_q;

endmodule
